// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
//   CW_DEF          default counter / coordinate width
//   SVGA_*          800x600@60 timing (40 MHz pixel clock)
//   VGA_*           640x480@60 timing (25.175 MHz pixel clock)
//   FLD_*           position of each field in cfg_h / cfg_v, in units of CW bits
package vga_timing_pkg;

  localparam int CW_DEF = 11;

  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BACK   = 88;
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FRONT  = 40;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BACK   = 23;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FRONT  = 1;

  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FRONT   = 10;

  // {sync, back, active, front}, sync in the most significant slot
  localparam int FLD_SYNC   = 3;
  localparam int FLD_BACK   = 2;
  localparam int FLD_ACTIVE = 1;
  localparam int FLD_FRONT  = 0;

endpackage

// File: rtl/vga_timing_if.sv
// Configuration and video-timing bundle of the raster generator.
//   master : host / consumer side (drives timing_en and cfg_*, receives timing)
//   slave  : the generator itself
// Signals:
//   timing_en, cfg_valid, cfg_h[4*CW], cfg_v[4*CW], cfg_pol[2]   host -> generator
//   cfg_pending, cfg_err, hsync, vsync, de, x, y,
//   frame_start, line_start                                      generator -> host
interface vga_timing_if
  import vga_timing_pkg::*;
#(
  parameter int CW = CW_DEF
);

  logic            timing_en;
  logic            cfg_valid;
  logic [4*CW-1:0] cfg_h;
  logic [4*CW-1:0] cfg_v;
  logic [1:0]      cfg_pol;
  logic            cfg_pending;
  logic            cfg_err;
  logic            hsync;
  logic            vsync;
  logic            de;
  logic [CW-1:0]   x;
  logic [CW-1:0]   y;
  logic            frame_start;
  logic            line_start;

  modport master (
    output timing_en, cfg_valid, cfg_h, cfg_v, cfg_pol,
    input  cfg_pending, cfg_err, hsync, vsync, de, x, y, frame_start, line_start
  );

  modport slave (
    input  timing_en, cfg_valid, cfg_h, cfg_v, cfg_pol,
    output cfg_pending, cfg_err, hsync, vsync, de, x, y, frame_start, line_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): counts 0..total-1 in the order
// sync, back porch, active, front porch, and decodes the position.
// Ports:
//   vga_clk, rst_n                 pixel clock, async active-low reset
//   clr                            force count to 0 (has priority over step)
//   step                           advance one position, wrapping after the last
//   sync_len/back_len/
//   active_len/front_len           segment lengths of the active timing set
//   cnt                            current position
//   last                           cnt is the final position of the axis
//   in_sync, in_active             position decodes
//   offset                         cnt relative to the first active position
module vga_axis_counter #(
  parameter int CW = 11
) (
  input  logic          vga_clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  input  logic [CW-1:0] sync_len,
  input  logic [CW-1:0] back_len,
  input  logic [CW-1:0] active_len,
  input  logic [CW-1:0] front_len,
  output logic [CW-1:0] cnt,
  output logic          last,
  output logic          in_sync,
  output logic          in_active,
  output logic [CW-1:0] offset
);

  logic [CW-1:0] cnt_p0;
  logic [CW-1:0] act_start;
  logic [CW-1:0] act_end;
  logic [CW-1:0] last_val;

  // Totals are validated to fit in CW bits, so these sums never wrap.
  assign act_start = sync_len + back_len;
  assign act_end   = act_start + active_len;
  assign last_val  = act_end + front_len - CW'(1);

  // Stage p0: axis position
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (clr) begin
      cnt_p0 <= '0;
    end else if (step) begin
      cnt_p0 <= last ? '0 : cnt_p0 + CW'(1);
    end
  end

  assign cnt       = cnt_p0;
  assign last      = (cnt_p0 == last_val);
  assign in_sync   = (cnt_p0 < sync_len);
  assign in_active = (cnt_p0 >= act_start) && (cnt_p0 < act_end);
  assign offset    = cnt_p0 - act_start;

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-configurable VGA/SVGA raster timing generator.
// Holds an active and a pending timing set; a new set is validated on
// cfg_valid, parked as pending and swapped in only when the raster wraps to
// the origin (or immediately while the raster is disabled). All video outputs
// are registered one cycle after the counter state and mutually aligned.
// Ports:
//   vga_clk   pixel clock
//   rst_n     asynchronous active-low reset
//   bus       vga_timing_if.slave: timing_en, cfg_valid/cfg_h/cfg_v/cfg_pol in;
//             cfg_pending, cfg_err, hsync, vsync, de, x, y, frame_start,
//             line_start out
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CW       = CW_DEF,
  parameter int   H_SYNC   = SVGA_H_SYNC,
  parameter int   H_BACK   = SVGA_H_BACK,
  parameter int   H_ACTIVE = SVGA_H_ACTIVE,
  parameter int   H_FRONT  = SVGA_H_FRONT,
  parameter int   V_SYNC   = SVGA_V_SYNC,
  parameter int   V_BACK   = SVGA_V_BACK,
  parameter int   V_ACTIVE = SVGA_V_ACTIVE,
  parameter int   V_FRONT  = SVGA_V_FRONT,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input logic         vga_clk,
  input logic         rst_n,
  vga_timing_if.slave bus
);

  localparam logic [4*CW-1:0] H_DEF = {CW'(H_SYNC), CW'(H_BACK), CW'(H_ACTIVE), CW'(H_FRONT)};
  localparam logic [4*CW-1:0] V_DEF = {CW'(V_SYNC), CW'(V_BACK), CW'(V_ACTIVE), CW'(V_FRONT)};
  localparam logic [CW+1:0]   TOTAL_MAX = {2'b00, {CW{1'b1}}};

  function automatic logic [CW-1:0] fld(input logic [4*CW-1:0] cfg, input int idx);
    return cfg[idx*CW +: CW];
  endfunction

  // Axis total with two guard bits so an oversized set is detectable.
  function automatic logic [CW+1:0] axis_total(input logic [4*CW-1:0] cfg);
    return (CW+2)'(fld(cfg, FLD_SYNC)) + (CW+2)'(fld(cfg, FLD_BACK))
         + (CW+2)'(fld(cfg, FLD_ACTIVE)) + (CW+2)'(fld(cfg, FLD_FRONT));
  endfunction

  function automatic logic cfg_ok(input logic [4*CW-1:0] h, input logic [4*CW-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (fld(h, i) == '0 || fld(v, i) == '0) ok = 1'b0;
    end
    if (axis_total(h) > TOTAL_MAX || axis_total(v) > TOTAL_MAX) ok = 1'b0;
    return ok;
  endfunction

  logic [4*CW-1:0] h_act_q, v_act_q, h_pend_q, v_pend_q;
  logic [1:0]      pol_act_q, pol_pend_q;
  logic            cfg_pending_q, cfg_err_q;

  logic            run;
  logic            h_last, v_last, h_in_sync, v_in_sync, h_in_active, v_in_active;
  logic [CW-1:0]   h_cnt_p0, v_cnt_p0, h_off, v_off;
  logic            frame_wrap, apply, cfg_new_ok;
  logic            h_pol, v_pol;

  assign run        = bus.timing_en;
  assign frame_wrap = run && h_last && v_last;
  assign apply      = cfg_pending_q && (frame_wrap || !run);
  assign cfg_new_ok = cfg_ok(bus.cfg_h, bus.cfg_v);
  assign h_pol      = pol_act_q[1];
  assign v_pol      = pol_act_q[0];

  vga_axis_counter #(.CW(CW)) u_h_axis (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .clr        (!run),
    .step       (run),
    .sync_len   (fld(h_act_q, FLD_SYNC)),
    .back_len   (fld(h_act_q, FLD_BACK)),
    .active_len (fld(h_act_q, FLD_ACTIVE)),
    .front_len  (fld(h_act_q, FLD_FRONT)),
    .cnt        (h_cnt_p0),
    .last       (h_last),
    .in_sync    (h_in_sync),
    .in_active  (h_in_active),
    .offset     (h_off)
  );

  vga_axis_counter #(.CW(CW)) u_v_axis (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .clr        (!run),
    .step       (run && h_last),
    .sync_len   (fld(v_act_q, FLD_SYNC)),
    .back_len   (fld(v_act_q, FLD_BACK)),
    .active_len (fld(v_act_q, FLD_ACTIVE)),
    .front_len  (fld(v_act_q, FLD_FRONT)),
    .cnt        (v_cnt_p0),
    .last       (v_last),
    .in_sync    (v_in_sync),
    .in_active  (v_in_active),
    .offset     (v_off)
  );

  // Configuration shadow: apply takes the already-registered pending set, so a
  // cfg_valid landing on the apply cycle becomes the next pending set.
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_act_q       <= H_DEF;
      v_act_q       <= V_DEF;
      pol_act_q     <= {H_POL, V_POL};
      h_pend_q      <= H_DEF;
      v_pend_q      <= V_DEF;
      pol_pend_q    <= {H_POL, V_POL};
      cfg_pending_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      if (apply) begin
        h_act_q   <= h_pend_q;
        v_act_q   <= v_pend_q;
        pol_act_q <= pol_pend_q;
      end
      if (bus.cfg_valid && cfg_new_ok) begin
        h_pend_q      <= bus.cfg_h;
        v_pend_q      <= bus.cfg_v;
        pol_pend_q    <= bus.cfg_pol;
        cfg_pending_q <= 1'b1;
      end else if (apply) begin
        cfg_pending_q <= 1'b0;
      end
      cfg_err_q <= bus.cfg_valid && !cfg_new_ok;
    end
  end

  logic          hsync_p1, vsync_p1, de_p1, frame_start_p1, line_start_p1;
  logic [CW-1:0] x_p1, y_p1;

  // Stage p1: registered video outputs, one cycle behind the counters
  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_p1       <= ~H_POL;
      vsync_p1       <= ~V_POL;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      frame_start_p1 <= 1'b0;
      line_start_p1  <= 1'b0;
    end else if (!run) begin
      hsync_p1       <= ~h_pol;
      vsync_p1       <= ~v_pol;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      frame_start_p1 <= 1'b0;
      line_start_p1  <= 1'b0;
    end else begin
      hsync_p1       <= h_in_sync ? h_pol : ~h_pol;
      vsync_p1       <= v_in_sync ? v_pol : ~v_pol;
      de_p1          <= h_in_active && v_in_active;
      x_p1           <= (h_in_active && v_in_active) ? h_off : '0;
      y_p1           <= (h_in_active && v_in_active) ? v_off : '0;
      frame_start_p1 <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      line_start_p1  <= (h_cnt_p0 == '0);
    end
  end

  assign bus.hsync       = hsync_p1;
  assign bus.vsync       = vsync_p1;
  assign bus.de          = de_p1;
  assign bus.x           = x_p1;
  assign bus.y           = y_p1;
  assign bus.frame_start = frame_start_p1;
  assign bus.line_start  = line_start_p1;
  assign bus.cfg_pending = cfg_pending_q;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a reduced default raster
// (h 3/2/6/2 = 13, v 2/1/4/1 = 8, 104 clocks per frame).
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int CW = 11;
  localparam int HS = 3, HB = 2, HA = 6, HF = 2;
  localparam int VS = 2, VB = 1, VA = 4, VF = 1;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  vga_timing_if #(.CW(CW)) bus();

  vga_timing_gen #(
    .CW(CW), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  function automatic logic [4*CW-1:0] pack(input int s, input int b, input int a, input int f);
    return {CW'(s), CW'(b), CW'(a), CW'(f)};
  endfunction

  // Leaves the bench one sample after the capturing edge.
  task automatic send_cfg(input logic [4*CW-1:0] h, input logic [4*CW-1:0] v, input logic [1:0] pol);
    bus.cfg_h     = h;
    bus.cfg_v     = v;
    bus.cfg_pol   = pol;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_fs(input string tag, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!bus.frame_start && cnt < 5000);
    check(tag, int'(bus.frame_start), 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".hsync"}, int'(bus.hsync), 1);
    check({tag, ".vsync"}, int'(bus.vsync), 1);
    check({tag, ".de"}, int'(bus.de), 0);
    check({tag, ".x"}, int'(bus.x), 0);
    check({tag, ".y"}, int'(bus.y), 0);
    check({tag, ".fs"}, int'(bus.frame_start), 0);
    check({tag, ".ls"}, int'(bus.line_start), 0);
  endtask

  // Starts on a frame_start sample, ends on the next frame_start sample.
  task automatic run_frame(input string tag, input int hs, input int hb, input int ha, input int hf,
                           input int vs, input int vb, input int va, input int vf,
                           input logic hp, input logic vp);
    int n, hs_n, vs_n, de_n, ls_n, first_de, fx, fy, mx, my, bad, ht, vt;
    bit seen;
    n = 0; hs_n = 0; vs_n = 0; de_n = 0; ls_n = 0; first_de = -1;
    fx = -1; fy = -1; mx = 0; my = 0; bad = 0; seen = 0;
    ht = hs + hb + ha + hf;
    vt = vs + vb + va + vf;
    check({tag, ".fs0"}, int'(bus.frame_start), 1);
    check({tag, ".ls0"}, int'(bus.line_start), 1);
    do begin
      if (bus.hsync == hp) hs_n++;
      if (bus.vsync == vp) vs_n++;
      if (bus.line_start) ls_n++;
      if (bus.de) begin
        de_n++;
        if (!seen) begin
          seen = 1; first_de = n; fx = int'(bus.x); fy = int'(bus.y);
        end
        if (int'(bus.x) > mx) mx = int'(bus.x);
        if (int'(bus.y) > my) my = int'(bus.y);
      end else if (bus.x != '0 || bus.y != '0) begin
        bad++;
      end
      tick();
      n++;
    end while (!bus.frame_start && n < 4000);
    check({tag, ".period"}, n, ht * vt);
    check({tag, ".hsync_act"}, hs_n, hs * vt);
    check({tag, ".vsync_act"}, vs_n, vs * ht);
    check({tag, ".de_cnt"}, de_n, ha * va);
    check({tag, ".lines"}, ls_n, vt);
    check({tag, ".first_de"}, first_de, (vs + vb) * ht + hs + hb);
    check({tag, ".first_x"}, fx, 0);
    check({tag, ".first_y"}, fy, 0);
    check({tag, ".max_x"}, mx, ha - 1);
    check({tag, ".max_y"}, my, va - 1);
    check({tag, ".xy_outside_de"}, bad, 0);
  endtask

  initial begin
    int cnt, bad;
    bus.timing_en = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_h     = '0;
    bus.cfg_v     = '0;
    bus.cfg_pol   = 2'b00;

    // Reset state
    repeat (3) tick();
    check_idle("rst");
    check("rst.pending", int'(bus.cfg_pending), 0);
    check("rst.err", int'(bus.cfg_err), 0);

    // Default timing, two frames
    rst_n = 1'b1;
    bus.timing_en = 1'b1;
    wait_fs("t1.fs_seen", cnt);
    check("t1.fs_latency", cnt, 1);
    run_frame("t1.f0", HS, HB, HA, HF, VS, VB, VA, VF, 1'b0, 1'b0);
    run_frame("t1.f1", HS, HB, HA, HF, VS, VB, VA, VF, 1'b0, 1'b0);

    // Mid-frame reconfiguration waits for the frame boundary
    repeat (20) tick();
    send_cfg(pack(2, 1, 5, 3), pack(1, 2, 3, 1), 2'b00);
    check("t3.pending", int'(bus.cfg_pending), 1);
    check("t3.err", int'(bus.cfg_err), 0);
    wait_fs("t3.fs_seen", cnt);
    check("t3.rest_of_old_frame", cnt, 104 - 21);
    check("t3.pending_cleared", int'(bus.cfg_pending), 0);
    run_frame("t3.B", 2, 1, 5, 3, 1, 2, 3, 1, 1'b0, 1'b0);

    // Disable mid-line for 50 clocks
    repeat (4) tick();
    bus.timing_en = 1'b0;
    tick();
    check_idle("t5.off");
    bad = 0;
    repeat (49) begin
      tick();
      if (bus.de || bus.frame_start || bus.line_start || !bus.hsync || !bus.vsync ||
          bus.x != '0 || bus.y != '0) bad++;
    end
    check("t5.idle_cycles_bad", bad, 0);
    bus.timing_en = 1'b1;
    tick();
    check("t5.reen_fs", int'(bus.frame_start), 1);
    check("t5.reen_ls", int'(bus.line_start), 1);
    run_frame("t5.B", 2, 1, 5, 3, 1, 2, 3, 1, 1'b0, 1'b0);

    // Rejected sets, total-width boundary, last accepted set wins
    repeat (5) tick();
    send_cfg(pack(2, 1, 0, 3), pack(1, 2, 3, 1), 2'b00);
    check("t4.zero_err", int'(bus.cfg_err), 1);
    check("t4.zero_pending", int'(bus.cfg_pending), 0);
    tick();
    check("t4.err_one_cycle", int'(bus.cfg_err), 0);
    send_cfg(pack(2, 1, 5, 3), pack(1, 2, 3, 0), 2'b00);
    check("t4.vzero_err", int'(bus.cfg_err), 1);
    send_cfg(pack(1000, 1000, 1000, 1000), pack(1, 2, 3, 1), 2'b00);
    check("t4.ovf_err", int'(bus.cfg_err), 1);
    check("t4.ovf_pending", int'(bus.cfg_pending), 0);
    wait_fs("t4.fs_seen", cnt);
    run_frame("t4.B_kept", 2, 1, 5, 3, 1, 2, 3, 1, 1'b0, 1'b0);
    repeat (5) tick();
    send_cfg(pack(2000, 20, 20, 7), pack(1, 2, 3, 1), 2'b00);
    check("t4.max_total_err", int'(bus.cfg_err), 0);
    check("t4.max_total_pending", int'(bus.cfg_pending), 1);
    send_cfg(pack(2000, 20, 20, 8), pack(1, 2, 3, 1), 2'b00);
    check("t4.over_total_err", int'(bus.cfg_err), 1);
    check("t4.over_total_pending", int'(bus.cfg_pending), 1);
    send_cfg(pack(HS, HB, HA, HF), pack(VS, VB, VA, VF), 2'b11);
    check("t4.pol_err", int'(bus.cfg_err), 0);
    wait_fs("t4.fs_seen2", cnt);
    run_frame("t4.C_pos", HS, HB, HA, HF, VS, VB, VA, VF, 1'b1, 1'b1);

    // cfg_valid on the exact wrap edge while set A is pending
    repeat (3) tick();
    send_cfg(pack(2, 2, 4, 2), pack(1, 1, 3, 1), 2'b00);
    check("t6.A_pending", int'(bus.cfg_pending), 1);
    repeat (98) tick();
    send_cfg(pack(2, 1, 3, 1), pack(1, 1, 2, 1), 2'b00);
    check("t6.pending_kept", int'(bus.cfg_pending), 1);
    tick();
    check("t6.A_fs", int'(bus.frame_start), 1);
    run_frame("t6.A", 2, 2, 4, 2, 1, 1, 3, 1, 1'b0, 1'b0);
    check("t6.B_applied_pending", int'(bus.cfg_pending), 0);
    run_frame("t6.B", 2, 1, 3, 1, 1, 1, 2, 1, 1'b0, 1'b0);

    // Reset mid-frame discards a pending 640x480 set
    repeat (10) tick();
    send_cfg(pack(VGA_H_SYNC, VGA_H_BACK, VGA_H_ACTIVE, VGA_H_FRONT),
             pack(VGA_V_SYNC, VGA_V_BACK, VGA_V_ACTIVE, VGA_V_FRONT), 2'b00);
    check("t6.vga_pending", int'(bus.cfg_pending), 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_idle("t6.rst");
    check("t6.rst_pending", int'(bus.cfg_pending), 0);
    tick();
    rst_n = 1'b1;
    wait_fs("t6.post_rst_fs", cnt);
    check("t6.post_rst_latency", cnt, 1);
    run_frame("t6.post_rst", HS, HB, HA, HF, VS, VB, VA, VF, 1'b0, 1'b0);
    run_frame("t6.post_rst2", HS, HB, HA, HF, VS, VB, VA, VF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
